delay_line_multitap: RTL and testbench
======================================

DELAY_LINE_MULTITAP -- requirements
Module: delay_line_multitap

Interface
REQ-001 Parameter DATA_W, default 16: sample width, two's-complement signed.
REQ-002 Parameter ADDR_W, default 12: buffer depth DEPTH = 2^ADDR_W samples.
REQ-003 Parameter TAPS, default 2: number of independent read taps (1..8).
REQ-004 Parameter FB_SHIFT, default 1: arithmetic right shift applied to the feedback term (used only with FEEDBACK_EN).
REQ-005 clkMain  in  1  single system clock; all logic on its rising edge.
REQ-006 rstN  in  1  reset, asynchronous assert, active-low.
REQ-007 sampleEn  in  1  one-cycle strobe; a new input sample is present.
REQ-008 inData  in  DATA_W  input sample.
REQ-009 delay  in  TAPS*ADDR_W  packed per-tap delay in samples; tap k uses bits [k*ADDR_W +: ADDR_W].
REQ-010 outData  out  TAPS*DATA_W  packed per-tap delayed samples; tap k uses bits [k*DATA_W +: DATA_W].
REQ-011 outValid  out  1  one-cycle pulse; outData has been updated.
REQ-012 busy  out  1  high whenever the FSM is not in IDLE.
REQ-013 overrun  out  1  sticky flag; a sampleEn was dropped.

Function
REQ-014 Storage SHALL be one DEPTH x DATA_W single-port synchronous RAM with registered read data and one access per cycle.
REQ-015 FSM states SHALL be IDLE, RD, WR and OUT; IDLE->RD on accepted sampleEn; RD stays TAPS cycles (tap index 0..TAPS-1); RD->WR; WR->OUT; OUT->IDLE.
REQ-016 sampleEn SHALL be accepted only in IDLE, and inData and delay SHALL be latched on acceptance.
REQ-017 A sampleEn in any state other than IDLE SHALL be ignored and SHALL set overrun.
REQ-018 In RD cycle k, tap k SHALL read address (wrPtr - delay_k) mod DEPTH, and read data SHALL be captured on the following cycle.
REQ-019 In WR, the latched sample (or feedback sum, REQ-030) SHALL be written at wrPtr, then wrPtr SHALL increment mod DEPTH, wrapping from DEPTH-1 to 0.
REQ-020 outValid SHALL be high for exactly one cycle (state OUT), TAPS+2 cycles after the cycle in which sampleEn was accepted.
REQ-021 outData SHALL hold its value between outValid pulses.
REQ-022 delay_k = 0 SHALL bypass the RAM: tap k output equals the value written in that WR.
REQ-023 fillCnt SHALL count samples written, saturating at DEPTH-1.
REQ-024 Tap k SHALL output 0 when delay_k > fillCnt, with fillCnt taken before the current write.
REQ-025 An accepted sampleEn in the same cycle as rstN deassertion SHALL NOT be required to be accepted.

Reset
REQ-026 rstN low SHALL immediately force: FSM=IDLE, wrPtr=0, fillCnt=0, outData=0, outValid=0, busy=0, overrun=0.
REQ-027 RAM contents SHALL NOT be cleared; fillCnt=0 guarantees stale data is never output.
REQ-028 Reset asserted mid-operation SHALL abort the event with no write and no outValid.

Configuration
REQ-029 Macro DELAY_LINE_MULTITAP_FEEDBACK_EN SHALL control feedback.
REQ-030 With DELAY_LINE_MULTITAP_FEEDBACK_EN defined, the WR value SHALL be sat(inData + (tap0 read value >>> FB_SHIFT)), saturated to the signed DATA_W range; the term is 0 when delay_0 = 0 or tap 0 is zeroed by REQ-024.
REQ-031 With DELAY_LINE_MULTITAP_FEEDBACK_EN undefined, the WR value SHALL be inData and no adder SHALL be synthesised.

Verification (DATA_W=16, ADDR_W=12, TAPS=2)
REQ-032 Reset; send values 1,2,3,... (one sampleEn per 10 cycles); delay0=0, delay1=3 -> out0=n; out1=0 for samples 1-3; out1=1 at sample 4; out1=2 at sample 5.
REQ-033 delay1=4095; send 4200 samples -> out1=n-4095 for n>=4096, including across wrPtr wrap 4095->0.
REQ-034 sampleEn in two consecutive cycles -> one outValid, 4 cycles after the first; overrun=1 and held until rstN low.
REQ-035 rstN pulsed low during RD -> no outValid, outData=0, overrun=0; next sample with delay1=1 -> out1=0.
REQ-036 DELAY_LINE_MULTITAP_FEEDBACK_EN defined, FB_SHIFT=1, delay0=1, input 1000 then zeros -> out0 = 0, 1000, 500, 250, 125.
REQ-037 DELAY_LINE_MULTITAP_FEEDBACK_EN defined, delay0=1, input 30000 every sample -> written value saturates at 32767 with no wrap to negative.

Source files
------------

// File: rtl/delay_line_multitap.sv
// Multi-tap delay line built on one single-port RAM; each sample is handled by an
// IDLE/RD/WR/OUT sequence. Define DELAY_LINE_MULTITAP_FEEDBACK_EN to feed tap 0 back.
module delay_line_multitap #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned TAPS     = 2,
  parameter int unsigned FB_SHIFT = 1
) (
  input  logic                     clkMain,
  input  logic                     rstN,
  input  logic                     sampleEn,
  input  logic [DATA_W-1:0]        inData,
  input  logic [TAPS*ADDR_W-1:0]   delay,
  output logic [TAPS*DATA_W-1:0]   outData,
  output logic                     outValid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;

  typedef enum logic [1:0] {StIdle, StRd, StWr, StOut} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    tap_q, tap_d;
  logic                accept;
  logic [ADDR_W-1:0]   wr_ptr_q, fill_q;
  logic [DATA_W-1:0]   in_q;
  logic [ADDR_W-1:0]   dly_q   [TAPS];
  logic [DATA_W-1:0]   cap_q   [TAPS];
  logic [DATA_W-1:0]   cap_now [TAPS];
  logic [DATA_W-1:0]   tap_val [TAPS];
  logic                rd_vld_q;
  logic [IDX_W-1:0]    rd_idx_q;
  logic [TAPS*DATA_W-1:0] out_q;
  logic                overrun_q;

  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_q;
  logic [DATA_W-1:0]   wr_val;
  logic [DATA_W-1:0]   mem [DEPTH];

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sampleEn) begin
          accept  = 1'b1;
          state_d = StRd;
          tap_d   = '0;
        end
      end
      StRd: begin
        if (tap_q == IDX_W'(TAPS - 1)) state_d = StWr;
        else                           tap_d   = tap_q + IDX_W'(1);
      end
      StWr:    state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Single port: the WR cycle owns the address, every RD cycle reads one tap.
  assign ram_we   = (state_q == StWr);
  assign ram_addr = ram_we ? wr_ptr_q : (wr_ptr_q - dly_q[tap_q]);

  always_ff @(posedge clkMain) begin
    if (ram_we) mem[ram_addr] <= wr_val;
    else        ram_q         <= mem[ram_addr];
  end

  // Read data lands one cycle after its RD cycle; the last tap lands during WR.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      cap_now[k] = (rd_vld_q && rd_idx_q == IDX_W'(k)) ? ram_q : cap_q[k];
      if (dly_q[k] == '0)         tap_val[k] = wr_val;
      else if (dly_q[k] > fill_q) tap_val[k] = '0;
      else                        tap_val[k] = cap_now[k];
    end
  end

`ifdef DELAY_LINE_MULTITAP_FEEDBACK_EN
  logic signed [DATA_W-1:0] fb_term;
  logic signed [DATA_W:0]   fb_sum;

  always_comb begin
    fb_term = '0;
    if (dly_q[0] != '0 && dly_q[0] <= fill_q) fb_term = $signed(cap_now[0]) >>> FB_SHIFT;
    fb_sum = $signed({in_q[DATA_W-1], in_q}) + $signed({fb_term[DATA_W-1], fb_term});
    if (fb_sum[DATA_W] != fb_sum[DATA_W-1]) begin
      wr_val = fb_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      wr_val = fb_sum[DATA_W-1:0];
    end
  end
`else
  logic unused_fb_shift;
  assign unused_fb_shift = (FB_SHIFT != 0);
  assign wr_val          = in_q;
`endif

  always_ff @(posedge clkMain or negedge rstN) begin
    if (!rstN) begin
      state_q   <= StIdle;
      tap_q     <= '0;
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      in_q      <= '0;
      rd_vld_q  <= 1'b0;
      rd_idx_q  <= '0;
      out_q     <= '0;
      overrun_q <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        dly_q[k] <= '0;
        cap_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      rd_vld_q <= (state_q == StRd);
      rd_idx_q <= tap_q;
      if (sampleEn && state_q != StIdle) overrun_q <= 1'b1;
      if (accept) begin
        in_q <= inData;
        for (int k = 0; k < TAPS; k++) dly_q[k] <= delay[k*ADDR_W +: ADDR_W];
      end
      for (int k = 0; k < TAPS; k++) cap_q[k] <= cap_now[k];
      if (state_q == StWr) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
        if (fill_q != '1) fill_q <= fill_q + ADDR_W'(1);
        for (int k = 0; k < TAPS; k++) out_q[k*DATA_W +: DATA_W] <= tap_val[k];
      end
    end
  end

  assign outData  = out_q;
  assign outValid = (state_q == StOut);
  assign busy     = (state_q != StIdle);
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_delay_line_multitap.sv
// Randomised self-checking bench for delay_line_multitap (DATA_W=16, ADDR_W=12, TAPS=2).
// Feedback scenarios are compiled only when DELAY_LINE_MULTITAP_FEEDBACK_EN is defined.
module tb_delay_line_multitap;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 12;
  localparam int TAPS     = 2;
  localparam int FB_SHIFT = 1;
  localparam int MAXFILL  = 4095;

  logic        clkMain  = 1'b0;
  logic        rstN     = 1'b0;
  logic        sampleEn = 1'b0;
  logic [15:0] inData   = '0;
  logic [23:0] delay    = '0;
  logic [31:0] outData;
  logic        outValid;
  logic        busy;
  logic        overrun;

  int checks   = 0;
  int failures = 0;
  int hist[$];  // every value written since reset, oldest first

  always #5 clkMain = ~clkMain;

  delay_line_multitap #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .TAPS    (TAPS),
    .FB_SHIFT(FB_SHIFT)
  ) dut (
    .clkMain (clkMain),
    .rstN    (rstN),
    .sampleEn(sampleEn),
    .inData  (inData),
    .delay   (delay),
    .outData (outData),
    .outValid(outValid),
    .busy    (busy),
    .overrun (overrun)
  );

  // Reference: tap d returns the sample written d events ago, or 0 if fewer were written.
  function automatic void model_step(input int din, input int d0, input int d1,
                                     output int e0, output int e1);
    int n, fill, t0, wv;
    n    = hist.size();
    fill = (n > MAXFILL) ? MAXFILL : n;
    t0   = (d0 == 0 || d0 > fill) ? 0 : hist[n - d0];
`ifdef DELAY_LINE_MULTITAP_FEEDBACK_EN
    wv = din + (t0 >>> FB_SHIFT);
    if (wv > 32767)  wv = 32767;
    if (wv < -32768) wv = -32768;
`else
    wv = din;
`endif
    e0 = (d0 == 0) ? wv : t0;
    e1 = (d1 == 0) ? wv : ((d1 > fill) ? 0 : hist[n - d1]);
    hist.push_back(wv);
  endfunction

  task automatic apply_reset();
    @(negedge clkMain);
    rstN     = 1'b0;
    sampleEn = 1'b0;
    @(negedge clkMain);
    rstN = 1'b1;
    hist.delete();
  endtask

  task automatic drive_sample(input logic [15:0] din, input logic [11:0] d0,
                              input logic [11:0] d1, output int lat,
                              output logic [31:0] od, output logic v_after,
                              output logic [31:0] od_after);
    @(negedge clkMain);
    sampleEn = 1'b1;
    inData   = din;
    delay    = {d1, d0};
    @(negedge clkMain);
    sampleEn = 1'b0;
    lat = 0;
    od  = '0;
    for (int i = 1; i <= 20; i++) begin
      if (outValid) begin
        lat = i;
        od  = outData;
        break;
      end
      @(negedge clkMain);
    end
    @(negedge clkMain);
    v_after  = outValid;
    od_after = outData;
  endtask

  task automatic test_reset();
    @(negedge clkMain);
    rstN = 1'b0;
    #2;
    checks += 4;
    if (outData !== 32'h0) begin failures++; $display("FAIL reset_outData got=%h exp=0", outData); end
    if (outValid !== 1'b0) begin failures++; $display("FAIL reset_outValid got=%b exp=0", outValid); end
    if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (overrun !== 1'b0)  begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    @(negedge clkMain);
    rstN = 1'b1;
    hist.delete();
  endtask

  task automatic test_basic();
    int e0, e1, lat;
    int e1c[6] = '{0, 0, 0, 1, 2, 3};
    logic [31:0] od, oa;
    logic va;
    apply_reset();
    for (int n = 1; n <= 6; n++) begin
      model_step(n, 0, 3, e0, e1);
      drive_sample(16'(n), 12'd0, 12'd3, lat, od, va, oa);
      checks += 6;
      if (lat != 4) begin failures++; $display("FAIL basic_latency n=%0d got=%0d exp=4", n, lat); end
      if (od[15:0] !== 16'(n)) begin failures++; $display("FAIL basic_out0 n=%0d got=%0d exp=%0d", n, od[15:0], n); end
      if (od[31:16] !== 16'(e1c[n-1])) begin
        failures++; $display("FAIL basic_out1 n=%0d got=%0d exp=%0d", n, od[31:16], e1c[n-1]);
      end
      if (od[31:16] !== 16'(e1)) begin failures++; $display("FAIL basic_out1_model n=%0d got=%0d exp=%0d", n, od[31:16], e1); end
      if (va !== 1'b0) begin failures++; $display("FAIL basic_pulse_width n=%0d got=%b exp=0", n, va); end
      if (oa !== od) begin failures++; $display("FAIL basic_hold n=%0d got=%h exp=%h", n, oa, od); end
      repeat (4) @(negedge clkMain);
    end
  endtask

  function automatic int pick_delay();
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return 0;
    if (r == 1) return $urandom_range(1, 8);
    if (r == 2) return $urandom_range(0, hist.size() + 2 > MAXFILL ? MAXFILL : hist.size() + 2);
    return $urandom_range(0, MAXFILL);
  endfunction

  task automatic test_random();
    int e0, e1, lat, d0, d1;
    logic [15:0] v;
    logic [31:0] od, oa;
    logic va;
    apply_reset();
    for (int n = 0; n < 300; n++) begin
      v  = 16'($urandom);
      d0 = pick_delay();
      d1 = pick_delay();
      model_step(int'($signed(v)), d0, d1, e0, e1);
      drive_sample(v, 12'(d0), 12'(d1), lat, od, va, oa);
      checks += 4;
      if (lat != 4) begin failures++; $display("FAIL rand_latency n=%0d got=%0d exp=4", n, lat); end
      if (od[15:0] !== 16'(e0)) begin
        failures++; $display("FAIL rand_out0 n=%0d d0=%0d got=%h exp=%h", n, d0, od[15:0], 16'(e0));
      end
      if (od[31:16] !== 16'(e1)) begin
        failures++; $display("FAIL rand_out1 n=%0d d1=%0d got=%h exp=%h", n, d1, od[31:16], 16'(e1));
      end
      if (va !== 1'b0) begin failures++; $display("FAIL rand_pulse_width n=%0d got=%b exp=0", n, va); end
    end
  endtask

  task automatic test_wrap();
    int e0, e1, lat;
    logic [31:0] od, oa;
    logic va;
    apply_reset();
    for (int n = 1; n <= 4200; n++) begin
      model_step(n, 0, 4095, e0, e1);
      drive_sample(16'(n), 12'd0, 12'd4095, lat, od, va, oa);
      checks += 2;
      if (lat != 4) begin failures++; $display("FAIL wrap_latency n=%0d got=%0d exp=4", n, lat); end
      if (od[31:16] !== 16'(e1)) begin failures++; $display("FAIL wrap_out1 n=%0d got=%0d exp=%0d", n, od[31:16], e1); end
      if (n >= 4096) begin
        checks++;
        if (od[31:16] !== 16'(n - 4095)) begin
          failures++; $display("FAIL wrap_out1_abs n=%0d got=%0d exp=%0d", n, od[31:16], n - 4095);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int e0, e1, lat, pulses;
    logic [15:0] a;
    logic [31:0] od, oa;
    logic va;
    a = 16'($urandom);
    model_step(int'($signed(a)), 2, 0, e0, e1);
    @(negedge clkMain);
    sampleEn = 1'b1;
    inData   = a;
    delay    = {12'd0, 12'd2};
    @(negedge clkMain);
    inData = ~a;
    delay  = {12'd5, 12'd5};
    @(negedge clkMain);
    sampleEn = 1'b0;
    pulses = 0;
    lat    = 0;
    od     = '0;
    for (int i = 2; i <= 12; i++) begin
      if (outValid) begin
        pulses++;
        if (lat == 0) begin lat = i; od = outData; end
      end
      @(negedge clkMain);
    end
    checks += 5;
    if (lat != 4) begin failures++; $display("FAIL b2b_latency got=%0d exp=4", lat); end
    if (pulses != 1) begin failures++; $display("FAIL b2b_pulses got=%0d exp=1", pulses); end
    if (od[15:0] !== 16'(e0)) begin failures++; $display("FAIL b2b_out0 got=%h exp=%h", od[15:0], 16'(e0)); end
    if (od[31:16] !== 16'(e1)) begin failures++; $display("FAIL b2b_out1 got=%h exp=%h", od[31:16], 16'(e1)); end
    if (overrun !== 1'b1) begin failures++; $display("FAIL b2b_overrun got=%b exp=1", overrun); end
    model_step(100, 1, 3, e0, e1);
    drive_sample(16'd100, 12'd1, 12'd3, lat, od, va, oa);
    checks += 2;
    if (overrun !== 1'b1) begin failures++; $display("FAIL b2b_overrun_sticky got=%b exp=1", overrun); end
    if (od !== {16'(e1), 16'(e0)}) begin failures++; $display("FAIL b2b_next got=%h exp=%h", od, {16'(e1), 16'(e0)}); end
  endtask

  task automatic test_reset_mid();
    int e0, e1, lat, pulses;
    logic [31:0] od, oa;
    logic va;
    @(negedge clkMain);
    sampleEn = 1'b1;
    inData   = 16'h1234;
    delay    = {12'd1, 12'd1};
    @(negedge clkMain);
    sampleEn = 1'b0;
    #2;
    rstN = 1'b0;
    #1;
    checks += 4;
    if (outData !== 32'h0) begin failures++; $display("FAIL mid_outData got=%h exp=0", outData); end
    if (overrun !== 1'b0)  begin failures++; $display("FAIL mid_overrun got=%b exp=0", overrun); end
    if (busy !== 1'b0)     begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    if (outValid !== 1'b0) begin failures++; $display("FAIL mid_outValid got=%b exp=0", outValid); end
    @(negedge clkMain);
    rstN = 1'b1;
    hist.delete();
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clkMain);
      if (outValid) pulses++;
    end
    checks++;
    if (pulses != 0) begin failures++; $display("FAIL mid_no_pulse got=%0d exp=0", pulses); end
    model_step(77, 0, 1, e0, e1);
    drive_sample(16'd77, 12'd0, 12'd1, lat, od, va, oa);
    checks += 3;
    if (od[31:16] !== 16'd0) begin failures++; $display("FAIL mid_out1 got=%h exp=0", od[31:16]); end
    if (od[15:0] !== 16'(e0)) begin failures++; $display("FAIL mid_out0 got=%h exp=%h", od[15:0], 16'(e0)); end
    if (lat != 4) begin failures++; $display("FAIL mid_latency got=%0d exp=4", lat); end
  endtask

`ifdef DELAY_LINE_MULTITAP_FEEDBACK_EN
  task automatic test_feedback_decay();
    int e0, e1, lat;
    int vin[5]  = '{1000, 0, 0, 0, 0};
    int exp0[5] = '{0, 1000, 500, 250, 125};
    logic [31:0] od, oa;
    logic va;
    apply_reset();
    for (int n = 0; n < 5; n++) begin
      model_step(vin[n], 1, 0, e0, e1);
      drive_sample(16'(vin[n]), 12'd1, 12'd0, lat, od, va, oa);
      checks += 2;
      if (od[15:0] !== 16'(exp0[n])) begin
        failures++; $display("FAIL fb_decay_out0 n=%0d got=%0d exp=%0d", n, od[15:0], exp0[n]);
      end
      if (od[31:16] !== 16'(e1)) begin
        failures++; $display("FAIL fb_decay_wr n=%0d got=%0d exp=%0d", n, od[31:16], e1);
      end
    end
  endtask

  task automatic test_feedback_sat();
    int e0, e1, lat, exp0;
    logic [31:0] od, oa;
    logic va;
    apply_reset();
    for (int n = 1; n <= 6; n++) begin
      model_step(30000, 1, 0, e0, e1);
      drive_sample(16'd30000, 12'd1, 12'd0, lat, od, va, oa);
      exp0 = (n == 1) ? 0 : ((n == 2) ? 30000 : 32767);
      checks += 3;
      if (od[15:0] !== 16'(exp0)) begin failures++; $display("FAIL fb_sat_out0 n=%0d got=%0d exp=%0d", n, od[15:0], exp0); end
      if (od[31:16] !== 16'(e1)) begin failures++; $display("FAIL fb_sat_wr n=%0d got=%0d exp=%0d", n, od[31:16], e1); end
      if (od[31] !== 1'b0) begin failures++; $display("FAIL fb_sat_sign n=%0d got=%h exp=positive", n, od[31:16]); end
    end
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
`ifdef DELAY_LINE_MULTITAP_FEEDBACK_EN
    test_feedback_decay();
    test_feedback_sat();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
